// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: W stage first, long-unit results queued behind it.
// Define WBARB_BYPASS_EN to let a result skip an empty buffer and write the same cycle.
module wb_port_arbiter #(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    RegWriteW,
    input  logic [4:0]              RdW,
    input  logic [31:0]             ResultW,
    input  logic                    LuValid,
    input  logic [4:0]              LuRd,
    input  logic [31:0]             LuData,
    output logic                    LuReady,
    output logic                    PipeHold,
    output logic                    RfWe,
    output logic [4:0]              RfRd,
    output logic [31:0]             RfWd,
    output logic [$clog2(DEPTH):0]  LuPending
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {IDLE, PEND, HOLD} state_e;

    state_e           state_q, state_d;
    logic [WW-1:0]    wait_q, wait_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [DEPTH-1:0] live_q, live_d;
    logic [4:0]       rd_q   [DEPTH];
    logic [31:0]      data_q [DEPTH];

    logic          pipe_eff, acc, push, byp_wr;
    logic          live0, dead0, live1, kill_head;
    logic [1:0]    npop;
    logic [AW-1:0] h1;

    always_comb begin
        h1        = rptr_q + AW'(1);
        PipeHold  = (state_q == HOLD);
        LuReady   = reset && (cnt_q != CW'(DEPTH));
        pipe_eff  = reset && RegWriteW && (RdW != 5'd0) && !PipeHold;
        acc       = LuValid && LuReady;
        live0     = (cnt_q != '0) && live_q[rptr_q];
        dead0     = (cnt_q != '0) && !live_q[rptr_q];
        live1     = (cnt_q > CW'(1)) && live_q[h1];
        byp_wr    = 1'b0;
`ifdef WBARB_BYPASS_EN
        byp_wr    = acc && (cnt_q == '0) && !pipe_eff && (LuRd != 5'd0);
`endif
        push      = acc && (LuRd != 5'd0) && !byp_wr;
        kill_head = pipe_eff && live0 && (rd_q[rptr_q] == RdW);

        RfWe = 1'b0;
        RfRd = '0;
        RfWd = '0;
        npop = 2'd0;
        if (pipe_eff) begin
            RfWe = 1'b1;
            RfRd = RdW;
            RfWd = ResultW;
            npop = {1'b0, dead0};
        end else if (live0) begin
            RfWe = 1'b1;
            RfRd = rd_q[rptr_q];
            RfWd = data_q[rptr_q];
            npop = 2'd1;
        end else if (dead0 && live1) begin
            // dead head retires for free, the next live entry takes the slot
            RfWe = 1'b1;
            RfRd = rd_q[h1];
            RfWd = data_q[h1];
            npop = 2'd2;
        end else if (byp_wr) begin
            RfWe = 1'b1;
            RfRd = LuRd;
            RfWd = LuData;
        end else begin
            npop = {1'b0, dead0};
        end

        live_d = live_q;
        if (pipe_eff) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rd_q[i] == RdW) live_d[i] = 1'b0;
            end
        end
        if (npop != 2'd0) live_d[rptr_q] = 1'b0;
        if (npop == 2'd2) live_d[h1] = 1'b0;
        if (push) live_d[wptr_q] = 1'b1;

        cnt_d  = cnt_q + CW'(push) - CW'(npop);
        rptr_d = rptr_q + AW'(npop);
        wptr_d = wptr_q + AW'(push);

        wait_d = wait_q;
        if (npop != 2'd0 || kill_head) begin
            wait_d = '0;
        end else if (state_q == PEND && live0 && wait_q != WW'(MAX_WAIT)) begin
            wait_d = wait_q + WW'(1);
        end

        state_d = PEND;
        if (cnt_d == '0) begin
            state_d = IDLE;
            wait_d  = '0;
        end else if (state_q == PEND && wait_d == WW'(MAX_WAIT)) begin
            state_d = HOLD;
        end

        LuPending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            LuPending = LuPending + CW'(live_q[i]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            wait_q  <= '0;
            cnt_q   <= '0;
            rptr_q  <= '0;
            wptr_q  <= '0;
            live_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]   <= '0;
                data_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cnt_q   <= cnt_d;
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            live_q  <= live_d;
            if (push) begin
                rd_q[wptr_q]   <= LuRd;
                data_q[wptr_q] <= LuData;
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: vector table, directed corner sequences, random vs queue model.
module tb_wb_port_arbiter;
    localparam int DEPTH    = 2;
    localparam int MAX_WAIT = 4;
`ifdef WBARB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        RegWriteW;
    logic [4:0]  RdW;
    logic [31:0] ResultW;
    logic        LuValid;
    logic [4:0]  LuRd;
    logic [31:0] LuData;
    logic        LuReady;
    logic        PipeHold;
    logic        RfWe;
    logic [4:0]  RfRd;
    logic [31:0] RfWd;
    logic [1:0]  LuPending;

    wb_port_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset),
        .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
        .LuValid(LuValid), .LuRd(LuRd), .LuData(LuData),
        .LuReady(LuReady), .PipeHold(PipeHold),
        .RfWe(RfWe), .RfRd(RfRd), .RfWd(RfWd),
        .LuPending(LuPending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;

    logic        s_we, s_rdy, s_hold;
    logic [4:0]  s_rd;
    logic [31:0] s_wd;
    logic [1:0]  s_pend;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] d;
        bit          live;
    } ent_t;

    ent_t m_q[$];
    int   m_wait;
    bit   m_hold;

    typedef struct {
        logic rw; logic [4:0] rd; logic [31:0] res;
        logic lv; logic [4:0] lrd; logic [31:0] ld;
        logic we; logic [4:0] wrd; logic [31:0] wd; logic [1:0] pend;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(logic rw, logic [4:0] rd, logic [31:0] res,
                               logic lv, logic [4:0] lrd, logic [31:0] ld,
                               logic we, logic [4:0] wrd, logic [31:0] wd,
                               logic [1:0] pend);
        vec_t r;
        r.rw = rw; r.rd = rd; r.res = res;
        r.lv = lv; r.lrd = lrd; r.ld = ld;
        r.we = we; r.wrd = wrd; r.wd = wd; r.pend = pend;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic mdl_reset();
        m_q.delete();
        m_wait = 0;
        m_hold = 1'b0;
    endtask

    // One cycle of the arbitration rules on a queue of results.
    task automatic mdl_step(input logic rw, input logic [4:0] rd, input logic [31:0] res,
                            input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                            output logic we, output logic [4:0] wrd, output logic [31:0] wd,
                            output logic rdy, output logic hold, output logic [1:0] pend);
        bit peff, acc, byp, pend_st, head_live, popped, hkill;
        int n, s0;
        s0   = m_q.size();
        hold = m_hold;
        rdy  = (s0 < DEPTH);
        n = 0;
        foreach (m_q[i]) if (m_q[i].live) n++;
        pend      = 2'(n);
        peff      = rw && (rd != 0) && !m_hold;
        acc       = lv && rdy;
        pend_st   = (s0 != 0) && !m_hold;
        head_live = (s0 != 0) && m_q[0].live;
        we = 1'b0; wrd = '0; wd = '0;
        popped = 1'b0; hkill = 1'b0; byp = 1'b0;
        if (m_q.size() != 0 && !m_q[0].live) begin
            m_q.delete(0);
            popped = 1'b1;
        end
        if (peff) begin
            we = 1'b1; wrd = rd; wd = res;
        end else if (m_q.size() != 0 && m_q[0].live) begin
            we = 1'b1; wrd = m_q[0].rd; wd = m_q[0].d;
            m_q.delete(0);
            popped = 1'b1;
        end else if (BYP && acc && s0 == 0 && lrd != 0) begin
            we = 1'b1; wrd = lrd; wd = ld; byp = 1'b1;
        end
        if (peff) begin
            foreach (m_q[i]) begin
                if (m_q[i].live && m_q[i].rd == rd) begin
                    m_q[i].live = 1'b0;
                    if (i == 0) hkill = 1'b1;
                end
            end
        end
        if (acc && lrd != 0 && !byp) m_q.push_back('{lrd, ld, 1'b1});
        if (popped || hkill || m_q.size() == 0) m_wait = 0;
        else if (pend_st && head_live) m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT;
        m_hold = pend_st && (m_q.size() != 0) && (m_wait == MAX_WAIT);
    endtask

    task automatic cyc(input logic rw, input logic [4:0] rd, input logic [31:0] res,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
        logic e_we, e_rdy, e_hold;
        logic [4:0] e_rd;
        logic [31:0] e_wd;
        logic [1:0] e_pend;
        RegWriteW = rw; RdW = rd; ResultW = res;
        LuValid = lv; LuRd = lrd; LuData = ld;
        mdl_step(rw, rd, res, lv, lrd, ld, e_we, e_rd, e_wd, e_rdy, e_hold, e_pend);
        @(negedge clk);
        s_we = RfWe; s_rd = RfRd; s_wd = RfWd;
        s_rdy = LuReady; s_hold = PipeHold; s_pend = LuPending;
        chk("m_we",   32'(s_we),   32'(e_we));
        chk("m_rd",   32'(s_rd),   32'(e_rd));
        chk("m_wd",   s_wd,        e_wd);
        chk("m_rdy",  32'(s_rdy),  32'(e_rdy));
        chk("m_hold", 32'(s_hold), 32'(e_hold));
        chk("m_pend", 32'(s_pend), 32'(e_pend));
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        RegWriteW = 1'b1; RdW = 5'd3; ResultW = 32'h1;
        LuValid = 1'b1; LuRd = 5'd4; LuData = 32'h2;
        mdl_reset();
        @(negedge clk);
        chk("rst_rdy",  32'(LuReady),   32'd0);
        chk("rst_we",   32'(RfWe),      32'd0);
        chk("rst_hold", 32'(PipeHold),  32'd0);
        chk("rst_pend", 32'(LuPending), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle();
        chk("post_rst_rd", 32'(s_rd), 32'd0);
        chk("post_rst_wd", s_wd, 32'd0);

        for (int i = 0; i < 5; i++) tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 7, 32'hDEADBEEF,
                        BYP, BYP ? 5'd7 : 5'd0, BYP ? 32'hDEADBEEF : 32'd0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0,
                        !BYP, BYP ? 5'd0 : 5'd7, BYP ? 32'd0 : 32'hDEADBEEF,
                        BYP ? 2'd0 : 2'd1));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(1, 3, 32'h33, 0, 0, 0, 1, 3, 32'h33, 0));
        tbl.push_back(v(1, 0, 32'h99, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 32'h55, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(1, 8, 32'h88, 1, 10, 32'hAA, 1, 8, 32'h88, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 10, 32'hAA, 1));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        foreach (tbl[i]) begin
            cyc(tbl[i].rw, tbl[i].rd, tbl[i].res, tbl[i].lv, tbl[i].lrd, tbl[i].ld);
            chk($sformatf("tbl%0d_we", i),   32'(s_we),   32'(tbl[i].we));
            chk($sformatf("tbl%0d_rd", i),   32'(s_rd),   32'(tbl[i].wrd));
            chk($sformatf("tbl%0d_wd", i),   s_wd,        tbl[i].wd);
            chk($sformatf("tbl%0d_pend", i), 32'(s_pend), 32'(tbl[i].pend));
        end

        // starvation: x3 every cycle, x9 waits MAX_WAIT cycles then forces a hold
        cyc(1, 3, 32'h300, 1, 9, 32'h900);
        for (int k = 0; k < MAX_WAIT; k++) begin
            cyc(1, 3, 32'h300, 0, 0, 0);
            chk("starve_blk_rd", 32'(s_rd), 32'd3);
            chk("starve_blk_hold", 32'(s_hold), 32'd0);
        end
        cyc(1, 3, 32'h300, 0, 0, 0);
        chk("starve_hold", 32'(s_hold), 32'd1);
        chk("starve_rd", 32'(s_rd), 32'd9);
        chk("starve_wd", s_wd, 32'h900);
        cyc(1, 3, 32'h300, 0, 0, 0);
        chk("starve_after_hold", 32'(s_hold), 32'd0);
        chk("starve_after_rd", 32'(s_rd), 32'd3);

        // full buffer back-pressure
        cyc(1, 3, 32'h301, 1, 4, 32'h44);
        cyc(1, 3, 32'h302, 1, 5, 32'h55);
        chk("fill_rdy1", 32'(s_rdy), 32'd1);
        for (int k = 0; k < 4; k++) begin
            cyc(1, 3, 32'h303, 1, 6, 32'h66);
            chk("fill_rdy0", 32'(s_rdy), 32'd0);
        end
        chk("fill_hold", 32'(s_hold), 32'd1);
        chk("fill_pop_rd", 32'(s_rd), 32'd4);
        cyc(1, 3, 32'h304, 1, 6, 32'h66);
        chk("fill_rdy_back", 32'(s_rdy), 32'd1);
        idle();
        chk("drain_x5", 32'(s_rd), 32'd5);
        chk("drain_x5_wd", s_wd, 32'h55);
        idle();
        chk("drain_x6", 32'(s_rd), 32'd6);
        idle();
        chk("drain_done", 32'(s_we), 32'd0);

        // WAW kill of a buffered entry
        cyc(1, 3, 32'h305, 1, 6, 32'h11);
        cyc(1, 6, 32'h22, 0, 0, 0);
        chk("kill_wd", s_wd, 32'h22);
        chk("kill_pend_pre", 32'(s_pend), 32'd1);
        idle();
        chk("kill_nowrite", 32'(s_we), 32'd0);
        chk("kill_pend", 32'(s_pend), 32'd0);
        idle();
        chk("kill_nowrite2", 32'(s_we), 32'd0);

        // dead head skipped, next entry written in the same idle cycle
        cyc(1, 3, 32'h306, 1, 6, 32'h11);
        cyc(1, 3, 32'h307, 1, 7, 32'h77);
        cyc(1, 6, 32'h23, 0, 0, 0);
        idle();
        chk("skip_rd", 32'(s_rd), 32'd7);
        chk("skip_wd", s_wd, 32'h77);
        idle();
        chk("skip_done", 32'(s_we), 32'd0);

        // reset mid-run with two entries buffered
        cyc(1, 3, 32'h308, 1, 11, 32'hB1);
        cyc(1, 3, 32'h309, 1, 12, 32'hB2);
        RegWriteW = 1'b1; RdW = 5'd3; LuValid = 1'b1; LuRd = 5'd13;
        reset = 1'b0;
        #1;
        chk("mid_rst_we",   32'(RfWe),      32'd0);
        chk("mid_rst_pend", 32'(LuPending), 32'd0);
        chk("mid_rst_hold", 32'(PipeHold),  32'd0);
        chk("mid_rst_rdy",  32'(LuReady),   32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        mdl_reset();
        for (int k = 0; k < 3; k++) begin
            idle();
            chk("mid_rst_stale", 32'(s_we), 32'd0);
        end

        for (int k = 0; k < 400; k++) begin
            cyc($urandom_range(0, 99) < 60, 5'($urandom_range(0, 7)), $urandom,
                $urandom_range(0, 99) < 40, 5'($urandom_range(0, 7)), $urandom);
        end
        for (int k = 0; k < 12; k++) idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
